// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit data-memory interface stage.
// Covers access size and error codes, FSM states and the request bundle.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_ILL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_SIZE     = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic                we;
        size_e               size;
        logic                uns;
        logic [LSU_XLEN-1:0] adr;
        logic [LSU_XLEN-1:0] wdata;
        logic [4:0]          rd;
    } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response and data-memory port bundle of the LSU stage.
// The slave modport is the LSU's view; the master modport is the CPU/memory side.
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            req_v;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_adr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;
    logic            resp_v;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;
    logic [1:0]      resp_err;
    logic            r_v;
    logic            w_v;
    logic [XLEN-1:0] data_adr;
    logic [XLEN-1:0] data_o;
    logic [3:0]      strobe;
    logic [XLEN-1:0] dmem_resp;
    logic            dmem_resp_v;

    modport slave (
        input  req_v, req_we, req_size, req_unsigned, req_adr, req_wdata, req_rd,
        input  dmem_resp, dmem_resp_v,
        output req_ready, resp_v, resp_data, resp_rd, resp_err,
        output r_v, w_v, data_adr, data_o, strobe
    );

    modport master (
        output req_v, req_we, req_size, req_unsigned, req_adr, req_wdata, req_rd,
        output dmem_resp, dmem_resp_v,
        input  req_ready, resp_v, resp_data, resp_rd, resp_err,
        input  r_v, w_v, data_adr, data_o, strobe
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, access error checks,
// and load-data shift plus sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_strobe,
    output logic [31:0] st_data,
    output err_e        acc_err,
    input  size_e       ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_uns,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Store byte-lane enables and lane-replicated write data.
    always_comb begin
        st_strobe = 4'b0000;
        st_data   = 32'h0000_0000;
        case (st_size)
            SZ_B: begin
                st_strobe = 4'b0001 << st_off;
                st_data   = {4{st_wdata[7:0]}};
            end
            SZ_H: begin
                st_strobe = 4'b0011 << st_off;
                st_data   = {2{st_wdata[15:0]}};
            end
            SZ_W: begin
                st_strobe = 4'b1111;
                st_data   = st_wdata;
            end
            default: begin
                st_strobe = 4'b0000;
                st_data   = 32'h0000_0000;
            end
        endcase
    end

    // Error classification; an illegal size outranks misalignment.
    always_comb begin
        acc_err = ERR_NONE;
        if (st_size == SZ_ILL) begin
            acc_err = ERR_SIZE;
        end else if ((st_size == SZ_H) && st_off[0]) begin
            acc_err = ERR_MISALIGN;
        end else if ((st_size == SZ_W) && (st_off != 2'b00)) begin
            acc_err = ERR_MISALIGN;
        end else begin
            acc_err = ERR_NONE;
        end
    end

    assign shifted_s = ld_word >> {ld_off, 3'b000};

    // Load extraction from the right-shifted memory word.
    always_comb begin
        ld_data = 32'h0000_0000;
        case (ld_size)
            SZ_B: begin
                if (ld_uns) begin
                    ld_data = {24'h00_0000, shifted_s[7:0]};
                end else begin
                    ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SZ_H: begin
                if (ld_uns) begin
                    ld_data = {16'h0000, shifted_s[15:0]};
                end else begin
                    ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            SZ_W: begin
                ld_data = shifted_s;
            end
            default: begin
                ld_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_dmem_if.sv
// Load/store interface stage: one request at a time, word-aligned memory access
// with byte strobes, ack watchdog, and a one-cycle response pulse.
module lsu_dmem_if
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    lsu_if.slave bus
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e          state_r;
    logic            req_ready_r;
    logic            resp_v_r;
    logic [XLEN-1:0] resp_data_r;
    logic [4:0]      resp_rd_r;
    err_e            resp_err_r;
    logic            r_v_r;
    logic            w_v_r;
    logic [XLEN-1:0] data_adr_r;
    logic [XLEN-1:0] data_o_r;
    logic [3:0]      strobe_r;
    logic [CNT_W-1:0] cnt_r;

    // Only the fields needed to finish the access are kept after accept.
    logic            we_r;
    size_e           ld_size_r;
    logic [1:0]      ld_off_r;
    logic            uns_r;
    logic [4:0]      rd_r;

    lsu_req_t        req_s;
    logic [3:0]      st_strobe_s;
    logic [31:0]     st_data_s;
    err_e            acc_err_s;
    logic [31:0]     ld_data_s;

    // Bundle the live request inputs.
    always_comb begin
        req_s       = '0;
        req_s.we    = bus.req_we;
        req_s.size  = size_e'(bus.req_size);
        req_s.uns   = bus.req_unsigned;
        req_s.adr   = bus.req_adr;
        req_s.wdata = bus.req_wdata;
        req_s.rd    = bus.req_rd;
    end

    lsu_align u_align (
        .st_size   (req_s.size),
        .st_off    (req_s.adr[1:0]),
        .st_wdata  (req_s.wdata),
        .st_strobe (st_strobe_s),
        .st_data   (st_data_s),
        .acc_err   (acc_err_s),
        .ld_size   (ld_size_r),
        .ld_off    (ld_off_r),
        .ld_uns    (uns_r),
        .ld_word   (bus.dmem_resp),
        .ld_data   (ld_data_s)
    );

    // Access FSM with request latch, watchdog and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            resp_v_r    <= 1'b0;
            resp_data_r <= '0;
            resp_rd_r   <= 5'd0;
            resp_err_r  <= ERR_NONE;
            r_v_r       <= 1'b0;
            w_v_r       <= 1'b0;
            data_adr_r  <= '0;
            data_o_r    <= '0;
            strobe_r    <= 4'b0000;
            cnt_r       <= '0;
            we_r        <= 1'b0;
            ld_size_r   <= SZ_B;
            ld_off_r    <= 2'b00;
            uns_r       <= 1'b0;
            rd_r        <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_v_r <= 1'b0;
                    if (bus.req_v) begin
                        we_r        <= req_s.we;
                        ld_size_r   <= req_s.size;
                        ld_off_r    <= req_s.adr[1:0];
                        uns_r       <= req_s.uns;
                        rd_r        <= req_s.rd;
                        cnt_r       <= '0;
                        req_ready_r <= 1'b0;
                        if (acc_err_s != ERR_NONE) begin
                            // Faulty requests never reach memory.
                            state_r     <= RESP;
                            resp_v_r    <= 1'b1;
                            resp_data_r <= '0;
                            resp_rd_r   <= req_s.rd;
                            resp_err_r  <= acc_err_s;
                        end else begin
                            state_r    <= ACCESS;
                            r_v_r      <= ~req_s.we;
                            w_v_r      <= req_s.we;
                            data_adr_r <= {req_s.adr[XLEN-1:2], 2'b00};
                            data_o_r   <= req_s.we ? st_data_s : 32'h0000_0000;
                            strobe_r   <= req_s.we ? st_strobe_s : 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.dmem_resp_v) begin
                        state_r     <= RESP;
                        r_v_r       <= 1'b0;
                        w_v_r       <= 1'b0;
                        resp_v_r    <= 1'b1;
                        resp_data_r <= we_r ? 32'h0000_0000 : ld_data_s;
                        resp_rd_r   <= rd_r;
                        resp_err_r  <= ERR_NONE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r     <= RESP;
                        r_v_r       <= 1'b0;
                        w_v_r       <= 1'b0;
                        resp_v_r    <= 1'b1;
                        resp_data_r <= '0;
                        resp_rd_r   <= rd_r;
                        resp_err_r  <= ERR_TIMEOUT;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RESP: begin
                    state_r     <= IDLE;
                    resp_v_r    <= 1'b0;
                    req_ready_r <= 1'b1;
                end
                default: begin
                    state_r     <= IDLE;
                    resp_v_r    <= 1'b0;
                    r_v_r       <= 1'b0;
                    w_v_r       <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.resp_v    = resp_v_r;
    assign bus.resp_data = resp_data_r;
    assign bus.resp_rd   = resp_rd_r;
    assign bus.resp_err  = resp_err_r;
    assign bus.r_v       = r_v_r;
    assign bus.w_v       = w_v_r;
    assign bus.data_adr  = data_adr_r;
    assign bus.data_o    = data_o_r;
    assign bus.strobe    = strobe_r;

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: stores, extended loads, error paths,
// ack watchdog and mid-access reset, against hand-computed expectations.
module tb_lsu_dmem_if;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lsu_if #(.XLEN(32)) bus ();

    lsu_dmem_if #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns in cycle 1 after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] adr, input logic [31:0] wdata, input logic [4:0] rd);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_adr      = adr;
        bus.req_wdata    = wdata;
        bus.req_rd       = rd;
        bus.req_v        = 1'b1;
        tick();
        bus.req_v        = 1'b0;
    endtask

    // Full access with ack in cycle 1; response checked in cycle 2, idle in cycle 3.
    task automatic access(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] adr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] mem_word,
                          input logic [31:0] exp_adr, input logic [3:0] exp_strobe,
                          input logic [31:0] exp_dout, input logic [31:0] exp_data);
        issue(we, size, uns, adr, wdata, rd);
        chk({tag, ".r_v"}, {31'd0, bus.r_v}, {31'd0, ~we});
        chk({tag, ".w_v"}, {31'd0, bus.w_v}, {31'd0, we});
        chk({tag, ".ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
        chk({tag, ".data_adr"}, bus.data_adr, exp_adr);
        chk({tag, ".strobe"}, {28'd0, bus.strobe}, {28'd0, exp_strobe});
        chk({tag, ".data_o"}, bus.data_o, exp_dout);
        chk({tag, ".no_early_resp"}, {31'd0, bus.resp_v}, 32'd0);
        bus.dmem_resp   = mem_word;
        bus.dmem_resp_v = 1'b1;
        tick();
        bus.dmem_resp_v = 1'b0;
        chk({tag, ".resp_v"}, {31'd0, bus.resp_v}, 32'd1);
        chk({tag, ".resp_data"}, bus.resp_data, exp_data);
        chk({tag, ".resp_rd"}, {27'd0, bus.resp_rd}, {27'd0, rd});
        chk({tag, ".resp_err"}, {30'd0, bus.resp_err}, 32'd0);
        chk({tag, ".bus_idle"}, {30'd0, bus.r_v, bus.w_v}, 32'd0);
        tick();
        chk({tag, ".resp_drop"}, {31'd0, bus.resp_v}, 32'd0);
        chk({tag, ".ready_back"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    // Request rejected at accept: response in cycle 1, no memory cycle.
    task automatic err_req(input string tag, input logic we, input logic [1:0] size,
                           input logic [31:0] adr, input logic [4:0] rd, input logic [1:0] exp_err);
        issue(we, size, 1'b0, adr, 32'h1234_5678, rd);
        chk({tag, ".no_mem"}, {30'd0, bus.r_v, bus.w_v}, 32'd0);
        chk({tag, ".resp_v"}, {31'd0, bus.resp_v}, 32'd1);
        chk({tag, ".resp_err"}, {30'd0, bus.resp_err}, {30'd0, exp_err});
        chk({tag, ".resp_data"}, bus.resp_data, 32'd0);
        chk({tag, ".resp_rd"}, {27'd0, bus.resp_rd}, {27'd0, rd});
        tick();
        chk({tag, ".resp_drop"}, {31'd0, bus.resp_v}, 32'd0);
        chk({tag, ".ready_back"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_v        = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_adr      = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_rd       = 5'd0;
        bus.dmem_resp    = 32'd0;
        bus.dmem_resp_v  = 1'b0;

        tick();
        chk("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst.resp_v", {31'd0, bus.resp_v}, 32'd0);
        chk("rst.rw", {30'd0, bus.r_v, bus.w_v}, 32'd0);
        chk("rst.strobe", {28'd0, bus.strobe}, 32'd0);
        chk("rst.data_adr", bus.data_adr, 32'd0);
        chk("rst.data_o", bus.data_o, 32'd0);
        chk("rst.resp_data", bus.resp_data, 32'd0);
        chk("rst.resp_err", {30'd0, bus.resp_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Stores: completion pulse carries zero data.
        access("sw", 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 32'h5555_5555,
               32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'd0);
        access("sb", 1'b1, 2'd0, 1'b0, 32'h0000_0102, 32'h0000_00AB, 5'd2, 32'h5555_5555,
               32'h0000_0100, 4'b0100, 32'hABAB_ABAB, 32'd0);
        access("sh", 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0000_00AB, 5'd3, 32'h5555_5555,
               32'h0000_0100, 4'b1100, 32'h00AB_00AB, 32'd0);

        // Loads from memory word 0x80FF7F01 at 0x200.
        access("lb203", 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'd0, 5'd4, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'hFFFF_FF80);
        access("lbu203", 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'd0, 5'd5, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'h0000_0080);
        access("lh202", 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'd0, 5'd6, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'hFFFF_80FF);
        access("lw200", 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 5'd17, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'h80FF_7F01);
        access("lb201", 1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'd0, 5'd8, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'h0000_007F);
        access("lbu202", 1'b0, 2'd0, 1'b1, 32'h0000_0202, 32'd0, 5'd9, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'h0000_00FF);
        access("lhu202", 1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'd0, 5'd10, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'h0000_80FF);
        access("lh200", 1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'd0, 5'd11, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'h0000_7F01);

        // Error paths.
        err_req("lw_mis", 1'b0, 2'd2, 32'h0000_0101, 5'd12, 2'd1);
        err_req("sw_mis", 1'b1, 2'd2, 32'h0000_0102, 5'd13, 2'd1);
        err_req("sh_mis", 1'b1, 2'd1, 32'h0000_0103, 5'd14, 2'd1);
        err_req("size3", 1'b0, 2'd3, 32'h0000_0100, 5'd15, 2'd2);
        err_req("size3_mis", 1'b0, 2'd3, 32'h0000_0101, 5'd16, 2'd2);

        // Watchdog: no ack, TIMEOUT=4.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 5'd18);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to.r_v_c%0d", i), {31'd0, bus.r_v}, 32'd1);
            chk($sformatf("to.resp_v_c%0d", i), {31'd0, bus.resp_v}, 32'd0);
            tick();
        end
        chk("to.r_v_drop", {31'd0, bus.r_v}, 32'd0);
        chk("to.resp_v", {31'd0, bus.resp_v}, 32'd1);
        chk("to.resp_err", {30'd0, bus.resp_err}, 32'd3);
        chk("to.resp_data", bus.resp_data, 32'd0);
        chk("to.resp_rd", {27'd0, bus.resp_rd}, 32'd18);
        chk("to.ready_busy", {31'd0, bus.req_ready}, 32'd0);
        tick();
        chk("to.ready_back", {31'd0, bus.req_ready}, 32'd1);
        chk("to.resp_drop", {31'd0, bus.resp_v}, 32'd0);

        // Asynchronous reset in the middle of an access.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 5'd19);
        chk("ar.r_v_before", {31'd0, bus.r_v}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.rw_async", {30'd0, bus.r_v, bus.w_v}, 32'd0);
        chk("ar.resp_v", {31'd0, bus.resp_v}, 32'd0);
        chk("ar.req_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("ar.ready_after", {31'd0, bus.req_ready}, 32'd1);

        // A stray ack while idle must not produce a response.
        bus.dmem_resp   = 32'hCAFE_F00D;
        bus.dmem_resp_v = 1'b1;
        tick();
        chk("stray.resp_v1", {31'd0, bus.resp_v}, 32'd0);
        tick();
        bus.dmem_resp_v = 1'b0;
        chk("stray.resp_v2", {31'd0, bus.resp_v}, 32'd0);
        chk("stray.ready", {31'd0, bus.req_ready}, 32'd1);

        access("lw_post", 1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 5'd7, 32'h80FF_7F01,
               32'h0000_0200, 4'h0, 32'd0, 32'h80FF_7F01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_if.md
Name: lsu_dmem_if

Overview:
Load/store interface stage between the CPU memory pipeline stage and the word-wide data memory (basic_mem port set: r_v, w_v, adr, data, strobe, resp, ack).
- Accepts one load/store request at a time and converts it to a word-aligned memory access with byte strobes.
- Waits for the memory ack, then returns byte/halfword/word load data, shifted and sign- or zero-extended, together with the destination register tag.
- Detects misaligned and illegal-size accesses and reports them as errors without touching memory; a watchdog aborts accesses whose ack never arrives.

Parameters:
XLEN, 32, data/address width; only 32 is supported.
TIMEOUT, 255, maximum number of cycles spent in ACCESS waiting for ack before the access is aborted; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_v  in  1  request valid from the CPU memory stage
req_ready  out  1  stage can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  load is zero-extended (LBU/LHU)
req_adr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-aligned
req_rd  in  5  destination register tag, echoed back in the response
resp_v  out  1  one-cycle response pulse
resp_data  out  XLEN  extended load data; 0 for stores and errors
resp_rd  out  5  echoed tag
resp_err  out  2  0 = ok, 1 = misaligned, 2 = illegal size, 3 = timeout
r_v  out  1  memory read request
w_v  out  1  memory write request
data_adr  out  XLEN  word-aligned address {adr[31:2],2'b00}
data_o  out  XLEN  store data replicated across byte lanes
strobe  out  4  byte-lane write enables; 0 on reads
dmem_resp  in  XLEN  memory read word
dmem_resp_v  in  1  memory ack

Behaviour:
- Reset (async, rst=1): state=IDLE; req_ready=1; resp_v, r_v, w_v=0; strobe=0; data_adr, data_o, resp_data=0; resp_rd=0; resp_err=0; timeout counter=0. An access in progress when reset asserts is dropped: r_v and w_v fall immediately (asynchronously).
- FSM states:
  - IDLE: req_ready=1. On req_v=1, latch the request. If there is an error, go to RESP; otherwise go to ACCESS.
  - ACCESS: hold r_v = !we, hold w_v = we, keep data_adr/data_o/strobe stable, and count cycles. If dmem_resp_v is sampled high, capture dmem_resp and go to RESP with err=0. If the count reaches TIMEOUT, go to RESP with err=3 and drop r_v/w_v.
  - RESP: resp_v=1 for exactly one cycle with resp_data, resp_rd and resp_err; then return to IDLE.
- Error checks at accept (priority order):
  - size==3 -> err=2.
  - size==1 with adr[0]=1 -> err=1.
  - size==2 with adr[1:0]!=0 -> err=1.
  - On any error there are no r_v/w_v cycles.
- Store lanes (off = adr[1:0]):
  - byte: strobe = 4'b0001<<off; data_o = {4{wdata[7:0]}}.
  - half: strobe = 4'b0011<<off; data_o = {2{wdata[15:0]}}.
  - word: strobe = 4'b1111; data_o = wdata.
- Load extraction: word >> (8*off), then truncate to 8/16/32 bits and sign-extend unless req_unsigned.
- Latency:
  - Request accepted at edge 0; ACCESS begins in cycle 1.
  - Ack sampled at edge k -> resp_v high during cycle k+1.
  - Minimum request-to-response is 2 cycles.
  - Error path: resp_v high in cycle 1.
- dmem_resp_v while IDLE or RESP is ignored.
- req_v while not IDLE is not accepted (req_ready=0); the upstream stage holds the request.
- Back-to-back operation: a new request may be accepted in the IDLE cycle immediately after RESP, giving a throughput of one request per 3 cycles minimum.
- Stores return resp_v with resp_data=0 as a completion pulse.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_ILL).
  - err enum (ERR_NONE, ERR_MISALIGN, ERR_SIZE, ERR_TIMEOUT).
  - FSM state enum (IDLE, ACCESS, RESP).
  - Packed request struct (we, size, unsigned, adr, wdata, rd).
- One combinational sub-module, lsu_align: computes strobe and data_o for stores, the extended load data, and the misaligned/illegal error flags. The FSM, request latch and watchdog counter stay in lsu_dmem_if.

Test Plan:
- SW adr=0x100 wdata=0xDEADBEEF, ack after 1 cycle -> w_v=1 for 1 cycle, data_adr=0x100, strobe=4'hF; resp_v at cycle 2, resp_err=0, resp_data=0.
- Memory word at 0x200 = 0x80FF7F01:
  - LB 0x203 -> 0xFFFFFF80.
  - LBU 0x203 -> 0x00000080.
  - LH 0x202 -> 0xFFFF80FF.
  - LW 0x200 -> 0x80FF7F01; resp_rd echoes the request tag.
- SB adr=0x102 wdata=0x000000AB -> strobe=4'b0100, data_o=0xABABABAB; SH adr=0x102 -> strobe=4'b1100.
- LW adr=0x101 -> no r_v; resp_v in cycle 1 with resp_err=1. size=3 -> resp_err=2.
- TIMEOUT=4, dmem_resp_v held 0 -> r_v high for 4 cycles, then resp_err=3; req_ready returns to 1 the following cycle.
- Assert rst mid-ACCESS -> r_v/w_v/resp_v=0 immediately; after release, req_ready=1 and a fresh LW completes normally; a stray dmem_resp_v while IDLE produces no resp_v.
